push_pop_seq: RTL and testbench
===============================

PUSH_POP_SEQ -- requirements
Module: push_pop_seq

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  begin PUSH/POP; sampled only when busy=0.
REQ-004 SHALL have port is_pop  input  1  1=POP, 0=PUSH; captured with start.
REQ-005 SHALL have port reg_list  input  8  R0..R7 mask; captured with start.
REQ-006 SHALL have port extra  input  1  PUSH: include LR (R14); POP: include PC; captured with start.
REQ-007 SHALL have port sp_in  input  32  current SP (R13); captured with start.
REQ-008 SHALL have port busy  output  1  stall request to decode/fetch.
REQ-009 SHALL have port rf_addr  output  4  register read (PUSH) or write (POP) index.
REQ-010 SHALL have port rf_we  output  1  POP load to rf_addr from dmem data.
REQ-011 SHALL have port dmem_addr  output  32  word address of current transfer.
REQ-012 SHALL have port dmem_we  output  1  PUSH store strobe.
REQ-013 SHALL have port dmem_byte_enable  output  4  4'hF during transfer, else 4'h0.
REQ-014 SHALL have port pc_load  output  1  POP of PC: dmem data captured as new PC.
REQ-015 SHALL have port sp_we  output  1  write sp_out to R13.
REQ-016 SHALL have port sp_out  output  32  updated SP.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, XFER, SPWB, DONE; IDLE->XFER on start with n>0, IDLE->DONE on start with n=0.
REQ-019 n = popcount(reg_list) + extra, range 0..9; addresses 32-bit, wrap modulo 2^32.
REQ-020 Captured list SHALL be held in a pending mask; XFER handles lowest set index per cycle, clears it; bit 8 maps to R14 (PUSH) or PC (POP).
REQ-021 PUSH: base = sp_in - 4n; k-th transfer (k=0..n-1) at base+4k, dmem_we=1, rf_addr=register.
REQ-022 POP: k-th transfer at sp_in+4k; rf_we=1 for R0..R7; for PC: rf_we=0, pc_load=1, rf_addr=4'hF.
REQ-023 Exactly one transfer per XFER cycle; dmem read data valid same cycle; XFER lasts exactly n cycles.
REQ-024 XFER->SPWB after last transfer; SPWB asserts sp_we one cycle, sp_out = sp_in-4n (PUSH) or sp_in+4n (POP).
REQ-025 SPWB->DONE; DONE asserts done one cycle, then ->IDLE; n=0 SHALL NOT assert sp_we.
REQ-026 busy=1 in XFER, SPWB, DONE and in the start cycle; total latency start->done = n+2 cycles (n>0), 1 cycle (n=0).
REQ-027 start while busy=1 SHALL be ignored; inputs other than start SHALL be don't-care outside IDLE.
REQ-028 rf_we, dmem_we, pc_load, sp_we, done SHALL be mutually exclusive per cycle, except that rf_we, dmem_we, and pc_load are exclusive only of sp_we and done.

Reset
REQ-029 rst low SHALL immediately force IDLE, clear pending mask, and force busy, rf_we, dmem_we, pc_load, sp_we, done, and dmem_byte_enable to 0, and rf_addr, dmem_addr, and sp_out to 0.
REQ-030 Reset mid-operation SHALL abort with no further strobes; partially written memory is not restored.
REQ-031 Reset release SHALL take effect on the first clk edge after rst goes high.

Configuration
REQ-032 Macro PUSH_POP_LR_PC_EN defined: extra handled per REQ-020..022.
REQ-033 Macro PUSH_POP_LR_PC_EN undefined: extra ignored (treated as 0), pc_load tied 0, n = popcount(reg_list).

Verification
REQ-034 PUSH reg_list=8'h11, extra=1, sp_in=0x2000 -> stores R0@0x1FF4, R4@0x1FF8, R14@0x1FFC; sp_we with sp_out=0x1FF4; done 5 cycles after start.
REQ-035 POP reg_list=8'h03, extra=1, sp_in=0x1FF4 -> rf_we R0@0x1FF4, R1@0x1FF8, pc_load@0x1FFC; sp_out=0x2000.
REQ-036 reg_list=0, extra=0 -> done 1 cycle after start; no rf_we/dmem_we/sp_we.
REQ-037 PUSH reg_list=8'hFF, sp_in=0x10 -> 8 stores, addresses wrap from 0xFFFFFFF0; sp_out=0xFFFFFFF0.
REQ-038 Assert rst low during XFER of 4-register POP -> all strobes 0 at once; next start behaves normally.
REQ-039 Pulse start during busy -> ignored; macro undefined with extra=1 -> no R14/PC transfer.

Source files
------------

// File: rtl/push_pop_seq.sv
// rtl/push_pop_seq.sv - multi-cycle PUSH/POP register-list sequencer
//
// Purpose: expands one PUSH or POP of a register list into one memory
// transfer per cycle, then writes back SP and pulses done.
// Ports:
//   clk, rst (async active-low)
//   start, is_pop, reg_list[7:0], extra, sp_in[31:0]  - request, captured when idle
//   busy                                             - stall to decode/fetch
//   rf_addr[3:0], rf_we, pc_load                     - register file / PC side
//   dmem_addr[31:0], dmem_we, dmem_byte_enable[3:0]  - data memory side
//   sp_we, sp_out[31:0], done                        - SP write-back and completion
// Configuration: define PUSH_POP_LR_PC_EN to honour `extra` (LR on PUSH,
// PC on POP); undefined, `extra` is ignored and pc_load is tied low.
module push_pop_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_pop,
  input  logic [7:0]  reg_list,
  input  logic        extra,
  input  logic [31:0] sp_in,
  output logic        busy,
  output logic [3:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_byte_enable,
  output logic        pc_load,
  output logic        sp_we,
  output logic [31:0] sp_out,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, XFER, SPWB, DONE} state_t;

  state_t      state;
  logic [8:0]  pending;
  logic        pop_q;
  logic [31:0] sp_final;

  logic        extra_eff;
  logic [8:0]  start_mask;
  logic [3:0]  start_n;
  logic [31:0] start_bytes;
  logic [8:0]  rest;
  logic [8:0]  scan;
  logic        scan_pop;
  logic [3:0]  low_idx;
  logic [3:0]  x_rf_addr;
  logic        x_rf_we;

`ifdef PUSH_POP_LR_PC_EN
  assign extra_eff = extra;
`else
  assign extra_eff = extra & 1'b0;
  assign pc_load   = 1'b0;
`endif

  assign start_mask  = {extra_eff, reg_list};
  assign start_bytes = {26'b0, start_n, 2'b00};
  // Pending still holds the transfer being issued this cycle; drop its lowest bit.
  assign rest        = pending & (pending - 9'd1);
  // In IDLE the first transfer is chosen from the fresh request, later from what remains.
  assign scan        = (state == IDLE) ? start_mask : rest;
  assign scan_pop    = (state == IDLE) ? is_pop : pop_q;
  assign busy        = (state != IDLE) || start;

  always_comb begin
    start_n = '0;
    for (int i = 0; i < 9; i++) start_n = start_n + {3'b0, start_mask[i]};
  end

  always_comb begin
    low_idx = '0;
    for (int i = 8; i >= 0; i--) if (scan[i]) low_idx = 4'(i);
  end

  // Bit 8 is R14 for PUSH and the PC (reported as index 15) for POP.
  assign x_rf_addr = (low_idx == 4'd8) ? (scan_pop ? 4'hF : 4'hE) : low_idx;
  assign x_rf_we   = scan_pop && (low_idx != 4'd8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pending          <= '0;
      pop_q            <= 1'b0;
      sp_final         <= '0;
      rf_addr          <= '0;
      rf_we            <= 1'b0;
      dmem_addr        <= '0;
      dmem_we          <= 1'b0;
      dmem_byte_enable <= 4'h0;
`ifdef PUSH_POP_LR_PC_EN
      pc_load          <= 1'b0;
`endif
      sp_we            <= 1'b0;
      sp_out           <= '0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pop_q    <= is_pop;
            sp_final <= is_pop ? sp_in + start_bytes : sp_in - start_bytes;
            if (start_n == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state            <= XFER;
              pending          <= start_mask;
              dmem_addr        <= is_pop ? sp_in : sp_in - start_bytes;
              rf_addr          <= x_rf_addr;
              rf_we            <= x_rf_we;
              dmem_we          <= !is_pop;
              dmem_byte_enable <= 4'hF;
`ifdef PUSH_POP_LR_PC_EN
              pc_load          <= is_pop && (low_idx == 4'd8);
`endif
            end
          end
        end
        XFER: begin
          pending <= rest;
          if (rest == 9'd0) begin
            state            <= SPWB;
            rf_addr          <= '0;
            rf_we            <= 1'b0;
            dmem_addr        <= '0;
            dmem_we          <= 1'b0;
            dmem_byte_enable <= 4'h0;
`ifdef PUSH_POP_LR_PC_EN
            pc_load          <= 1'b0;
`endif
            sp_we            <= 1'b1;
            sp_out           <= sp_final;
          end else begin
            dmem_addr <= dmem_addr + 32'd4;
            rf_addr   <= x_rf_addr;
            rf_we     <= x_rf_we;
`ifdef PUSH_POP_LR_PC_EN
            pc_load   <= pop_q && (low_idx == 4'd8);
`endif
          end
        end
        SPWB: begin
          state <= DONE;
          sp_we <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_push_pop_seq.sv
// tb/tb_push_pop_seq.sv - directed table-driven bench for push_pop_seq
module tb_push_pop_seq;

`ifdef PUSH_POP_LR_PC_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_pop;
  logic [7:0]  reg_list;
  logic        extra;
  logic [31:0] sp_in;
  logic        busy;
  logic [3:0]  rf_addr;
  logic        rf_we;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_byte_enable;
  logic        pc_load;
  logic        sp_we;
  logic [31:0] sp_out;
  logic        done;

  int checks = 0;
  int errors = 0;

  push_pop_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .extra(extra), .sp_in(sp_in), .busy(busy), .rf_addr(rf_addr), .rf_we(rf_we),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_byte_enable(dmem_byte_enable),
    .pc_load(pc_load), .sp_we(sp_we), .sp_out(sp_out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_pop;
    logic [7:0]  reg_list;
    logic        extra;
    logic [31:0] sp_in;
    int          exp_n;
    logic [31:0] exp_sp;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Register index of the k-th transfer: k-th set bit of the list, bit 8 = LR/PC.
  function automatic logic [3:0] kth_reg(input logic [8:0] m, input int k, input logic pop);
    int c = 0;
    kth_reg = 4'h0;
    for (int i = 0; i < 9; i++) begin
      if (m[i]) begin
        if (c == k) kth_reg = (i == 8) ? (pop ? 4'hF : 4'hE) : 4'(i);
        c++;
      end
    end
  endfunction

  task automatic run_vec(input vec_t v);
    logic [8:0] m;
    logic [3:0] r;
    m = {(L != 0) && v.extra, v.reg_list};
    @(negedge clk);
    start = 1'b1; is_pop = v.is_pop; reg_list = v.reg_list; extra = v.extra; sp_in = v.sp_in;
    #1 chk("busy_start_cycle", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; reg_list = 8'h5A; sp_in = 32'hDEAD_BEEF;
    for (int k = 0; k < v.exp_n; k++) begin
      r = kth_reg(m, k, v.is_pop);
      chk("xfer_addr", dmem_addr, v.exp_base + 32'(4 * k));
      chk("xfer_rf_addr", {28'b0, rf_addr}, {28'b0, r});
      chk("xfer_strobes", {25'b0, rf_we, dmem_we, pc_load, sp_we, done, busy, dmem_byte_enable == 4'hF},
          {25'b0, v.is_pop && r != 4'hF, !v.is_pop, v.is_pop && r == 4'hF, 1'b0, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
    end
    if (v.exp_n > 0) begin
      chk("spwb_strobes", {26'b0, rf_we, dmem_we, pc_load, sp_we, done, busy}, {26'b0, 6'b000101});
      chk("spwb_sp_out", sp_out, v.exp_sp);
      @(negedge clk);
    end
    chk("done_strobes", {26'b0, rf_we, dmem_we, pc_load, sp_we, done, busy}, {26'b0, 6'b000011});
    @(negedge clk);
    chk("after_done", {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_pop = 1'b0; reg_list = 8'h0; extra = 1'b0; sp_in = '0;

    vecs[0] = '{1'b0, 8'h11, 1'b1, 32'h2000, 2 + L, 32'h2000 - 32'(4 * (2 + L)), 32'h2000 - 32'(4 * (2 + L))};
    vecs[1] = '{1'b1, 8'h03, 1'b1, 32'h1FF4, 2 + L, 32'h1FF4 + 32'(4 * (2 + L)), 32'h1FF4};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 32'h3000, 0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 32'h10, 8, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    vecs[4] = '{1'b1, 8'h80, 1'b0, 32'hFFFF_FFFC, 1, 32'h0, 32'hFFFF_FFFC};
    vecs[5] = '{1'b1, 8'h00, 1'b1, 32'h500, L, 32'h500 + 32'(4 * L), 32'h500};
    vecs[6] = '{1'b0, 8'hA5, 1'b0, 32'h100, 4, 32'hF0, 32'hF0};

    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {busy, rf_we, dmem_we, pc_load, sp_we, done, dmem_byte_enable, rf_addr, 18'b0},
        32'h0);
    chk("reset_addr", dmem_addr | sp_out, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start pulsed while busy must not disturb the running PUSH of R0,R1 from 0x40
    @(negedge clk);
    start = 1'b1; is_pop = 1'b0; reg_list = 8'h03; extra = 1'b0; sp_in = 32'h40;
    @(negedge clk);
    is_pop = 1'b1; reg_list = 8'hFF; sp_in = 32'h9000;
    chk("busy_ign_x0", dmem_addr, 32'h38);
    @(negedge clk);
    start = 1'b0;
    chk("busy_ign_x1", {dmem_addr[15:0], 12'b0, rf_addr}, {16'h3C, 12'b0, 4'd1});
    @(negedge clk);
    chk("busy_ign_spwb", sp_out, 32'h38);
    @(negedge clk);
    chk("busy_ign_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("busy_ign_idle", {30'b0, busy, done}, 32'd0);

    // reset in the middle of a 4-register POP
    @(negedge clk);
    start = 1'b1; is_pop = 1'b1; reg_list = 8'h0F; sp_in = 32'h100;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_xfer", {31'b0, rf_we}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_strobes", {24'b0, busy, rf_we, dmem_we, pc_load, sp_we, done, dmem_byte_enable != 4'h0, 1'b0},
        32'h0);
    chk("rst_mid_addr", dmem_addr | sp_out | {28'b0, rf_addr}, 32'h0);
    @(negedge clk);
    chk("rst_hold", {30'b0, rf_we, done}, 32'h0);
    rst = 1'b1;
    run_vec(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
